bridge_demux: RTL and testbench
===============================

Name: bridge_demux

Overview:
- Parametrised one-master to N-slave bridge fabric for the Pocket APF bridge bus.
- Decodes master address against per-slave base/mask windows and forwards write/read strobes to exactly one slave.
- Tracks in-flight reads through a latency pipeline and returns the selected slave's read data to the master.
- Sits between the core's top-level bridge port and the core's register, RAM and loader slaves; replaces hand-wired per-slave connections.

Parameters:
- NUM_SLAVES, 4, number of slave channels (1..16).
- SLAVE_BASE, all zero, NUM_SLAVES*32-bit packed; slave i window base in bits [32*i+:32].
- SLAVE_MASK, all 32'hF000_0000, NUM_SLAVES*32-bit packed; compare mask for slave i.
- RD_LATENCY, 1, cycles from a slave's s_rd to valid s_rd_data (1..8), same for all slaves.
- UNMAPPED_DATA, 32'hFFFF_FFFF, value returned for reads that hit no window.
- SLAVE_LITTLE, all zero, NUM_SLAVES-bit mask; 1 = slave expects little-endian data (used only with the optional feature).

Ports:
- clk  in  1  bridge clock.
- reset_n  in  1  asynchronous, active-low reset.
- m_addr  in  32  master address.
- m_wr_data  in  32  master write data.
- m_wr  in  1  master write strobe, one cycle per access.
- m_rd  in  1  master read strobe, one cycle per access.
- m_endian_little  in  1  master data endianness.
- m_rd_data  out  32  read data returned to the master.
- s_addr  out  32  registered address, broadcast to all slaves.
- s_wr_data  out  NUM_SLAVES*32  per-slave write data (byte-swapped per lane when the optional feature is enabled).
- s_wr  out  NUM_SLAVES  one-hot write strobes.
- s_rd  out  NUM_SLAVES  one-hot read strobes.
- s_rd_data  in  NUM_SLAVES*32  per-slave read data.
- unmapped_err  out  1  one-cycle pulse when an access hits no window.
- proto_err  out  1  one-cycle pulse when m_wr and m_rd are asserted together.

Behaviour:
- Reset values: all outputs are 0. m_rd_data resets to 32'h0 and the read pipeline is cleared. Reset is asserted asynchronously; deassertion is synchronised by the caller.
- Decode: hit[i] = ((m_addr & MASK[i]) == (BASE[i] & MASK[i])). The lowest index wins on overlapping windows. The decode is combinational and is registered together with the strobes.
- Request stage (latency 1):
  - s_addr and s_wr_data register on any m_wr or m_rd.
  - s_wr[i] / s_rd[i] are asserted for exactly 1 cycle, in the cycle after the master strobe, only for the winning i.
  - Between accesses s_addr/s_wr_data hold their last value.
- Write with no hit: no s_wr is asserted; unmapped_err pulses in the same cycle the strobe would have appeared.
- Read tracking:
  - A shift pipeline of depth RD_LATENCY carries {valid, hit_any, index} per issued read.
  - At the tail, if valid, m_rd_data is loaded with s_rd_data[index], or UNMAPPED_DATA if no hit.
  - Master sees data 1+RD_LATENCY cycles after m_rd. m_rd_data holds until the next read completes.
- Back-to-back reads are accepted every cycle. Completions are delivered in order with no bubbles.
- Unmapped read: no s_rd is asserted; unmapped_err pulses at the request stage; UNMAPPED_DATA is returned with normal latency.
- m_wr and m_rd in the same cycle: the write proceeds, the read is dropped (no pipeline entry, m_rd_data unchanged), and proto_err pulses.
- A write issued while reads are in flight does not disturb the read pipeline.
- Reset mid-read: in-flight reads are discarded and no completion occurs after reset release.

Optional Feature:
- Macro: BRIDGE_DEMUX_ENDIAN_SWAP_EN.
- Defined: when m_endian_little != SLAVE_LITTLE[i], write data to slave i is byte-reversed ({b0,b1,b2,b3}). Read data from that slave is byte-reversed before loading m_rd_data. The endian mismatch bit is captured at request time and carried in the pipeline entry. UNMAPPED_DATA is never swapped.
- Undefined: data passes unmodified; m_endian_little and SLAVE_LITTLE are ignored.

Decomposition:
- Shared package pocket:
  - bridge_addr_t and bridge_data_t, reused.
  - New constant BRIDGE_MAX_SLAVES = 16.
  - New typedef bridge_rd_tag_t, packed {valid, hit, swap, index[3:0]}.
  - New function bswap32.
- One sub-module, bridge_rd_pipe: parametrised-depth shift register of bridge_rd_tag_t with async active-low clear.
- Decode and the output mux stay in bridge_demux.

Test Plan:
- NUM_SLAVES=4, BASE[i]=i<<28, RD_LATENCY=2. Write addr 32'h2000_0010, data 32'hDEAD_BEEF -> s_wr=4'b0100 one cycle later, s_addr=32'h2000_0010, s_wr_data lane2=32'hDEAD_BEEF, no error pulses.
- Reads every cycle to slaves 0,1,3, with each slave returning 32'h1111_1111*(i+1) -> m_rd_data = 32'h1111_1111, 32'h2222_2222, 32'h4444_4444 on consecutive cycles starting 3 cycles after the first m_rd.
- Read addr 32'h5000_0000 (no window) -> no s_rd asserted, unmapped_err pulses once, m_rd_data=32'hFFFF_FFFF after 3 cycles.
- Overlap: BASE[0]=BASE[1]=0, write addr 0 -> only s_wr[0]; m_wr and m_rd asserted together -> write forwarded, proto_err=1 for one cycle, m_rd_data unchanged.
- Reset_n driven low one cycle after m_rd -> all outputs 0 immediately; after release, no completion appears and m_rd_data stays 0.
- With BRIDGE_DEMUX_ENDIAN_SWAP_EN, SLAVE_LITTLE=4'b0001, m_endian_little=0: write 32'h1234_5678 to slave 0 -> lane0 = 32'h7856_3412; slave 0 returns 32'hAABB_CCDD -> m_rd_data = 32'hDDCC_BBAA.

Source files
------------

// File: rtl/pocket_pkg.sv
// Shared bridge-bus types for the Pocket APF core: address/data words,
// read-tracking tag carried through the read latency pipeline, and a
// byte-reversal helper for endian conversion.
package pocket_pkg;

  typedef logic [31:0] bridge_addr_t;
  typedef logic [31:0] bridge_data_t;

  localparam int BRIDGE_MAX_SLAVES = 16;

  // One in-flight read: whether it is live, whether it decoded to a slave,
  // whether its data must be byte-reversed, and which slave it targets.
  typedef struct packed {
    logic       valid;
    logic       hit;
    logic       swap;
    logic [3:0] index;
  } bridge_rd_tag_t;

  function automatic bridge_data_t bswap32(input bridge_data_t d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/bridge_rd_pipe.sv
// Fixed-depth shift register of read tags. A tag entering at tag_in appears
// at tag_out DEPTH cycles later; reset clears every stage so no stale read
// can complete after reset is released.
module bridge_rd_pipe
  import pocket_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  bridge_rd_tag_t tag_in,
  output bridge_rd_tag_t tag_out
);

  bridge_rd_tag_t stages [DEPTH];

  // Shift tags one stage per cycle; reset discards all in-flight reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/bridge_demux.sv
// One-master to NUM_SLAVES-slave bridge fabric. Decodes the master address
// against per-slave base/mask windows (lowest index wins), registers the
// address/data/strobes for the selected slave, and returns read data after
// the request stage plus RD_LATENCY cycles of slave latency.
// Optional feature macro: BRIDGE_DEMUX_ENDIAN_SWAP_EN (per-slave byte swap
// when master and slave endianness differ).
module bridge_demux
  import pocket_pkg::*;
#(
  parameter int                         NUM_SLAVES    = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE    = '0,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK    = {NUM_SLAVES{32'hF000_0000}},
  parameter int                         RD_LATENCY    = 1,
  parameter logic [31:0]                UNMAPPED_DATA = 32'hFFFF_FFFF,
  parameter logic [NUM_SLAVES-1:0]      SLAVE_LITTLE  = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  m_addr,
  input  logic [31:0]                  m_wr_data,
  input  logic                         m_wr,
  input  logic                         m_rd,
  input  logic                         m_endian_little,
  output logic [31:0]                  m_rd_data,
  output logic [31:0]                  s_addr,
  output logic [NUM_SLAVES*32-1:0]     s_wr_data,
  output logic [NUM_SLAVES-1:0]        s_wr,
  output logic [NUM_SLAVES-1:0]        s_rd,
  input  logic [NUM_SLAVES*32-1:0]     s_rd_data,
  output logic                         unmapped_err,
  output logic                         proto_err
);

  logic [NUM_SLAVES-1:0]    hit_vec;
  logic [NUM_SLAVES-1:0]    sel_onehot;
  logic                     hit_any;
  logic [3:0]               hit_idx;
  logic                     swap_sel;
  logic [NUM_SLAVES*32-1:0] wr_lanes;
  bridge_rd_tag_t           req_tag;
  bridge_rd_tag_t           tail_tag;
  bridge_data_t             rd_sel;

  // Address decode: match every window, then keep only the lowest-index hit.
  always_comb begin
    hit_vec    = '0;
    sel_onehot = '0;
    hit_idx    = '0;
    swap_sel   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit_vec[i] = ((m_addr & SLAVE_MASK[32*i +: 32]) ==
                    (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]));
    end
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        hit_idx       = 4'(i);
`ifdef BRIDGE_DEMUX_ENDIAN_SWAP_EN
        swap_sel      = (m_endian_little != SLAVE_LITTLE[i]);
`else
        swap_sel      = 1'b0;
`endif
      end
    end
    hit_any = |hit_vec;
  end

  // Per-lane write data, byte-reversed for slaves of the other endianness.
  always_comb begin
    wr_lanes = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
`ifdef BRIDGE_DEMUX_ENDIAN_SWAP_EN
      wr_lanes[32*i +: 32] = (m_endian_little != SLAVE_LITTLE[i]) ?
                             bswap32(m_wr_data) : m_wr_data;
`else
      wr_lanes[32*i +: 32] = m_wr_data;
`endif
    end
  end

`ifndef BRIDGE_DEMUX_ENDIAN_SWAP_EN
  logic unused_endian;
  assign unused_endian = ^{m_endian_little, SLAVE_LITTLE};
`endif

  // Request stage: register address/data and one-cycle strobes; a read that
  // collides with a write is dropped and flagged as a protocol error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_addr       <= '0;
      s_wr_data    <= '0;
      s_wr         <= '0;
      s_rd         <= '0;
      unmapped_err <= 1'b0;
      proto_err    <= 1'b0;
      req_tag      <= '0;
    end else begin
      s_wr         <= m_wr ? sel_onehot : '0;
      s_rd         <= (m_rd && !m_wr) ? sel_onehot : '0;
      unmapped_err <= (m_wr || m_rd) && !hit_any;
      proto_err    <= m_wr && m_rd;
      if (m_wr || m_rd) begin
        s_addr    <= m_addr;
        s_wr_data <= wr_lanes;
      end
      req_tag.valid <= m_rd && !m_wr;
      req_tag.hit   <= hit_any;
      req_tag.swap  <= swap_sel;
      req_tag.index <= hit_idx;
    end
  end

  // The request-stage tag travels RD_LATENCY more cycles, lining up with the
  // slave presenting its data RD_LATENCY cycles after its s_rd strobe.
  bridge_rd_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (req_tag),
    .tag_out (tail_tag)
  );

  // Select the read data lane of the slave named by the completing tag.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (tail_tag.index == 4'(i)) begin
        rd_sel = s_rd_data[32*i +: 32];
      end
    end
  end

  // Completion: load returned data (or the unmapped pattern) and hold it
  // until the next read completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rd_data <= '0;
    end else if (tail_tag.valid) begin
      if (!tail_tag.hit) begin
        m_rd_data <= UNMAPPED_DATA;
      end else if (tail_tag.swap) begin
        m_rd_data <= bswap32(rd_sel);
      end else begin
        m_rd_data <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_bridge_demux.sv
// Scoreboard bench for bridge_demux: stimulus pushes expected request-stage
// and completion results into queues, a negedge monitor pops and compares.
// A second instance with overlapping windows 0/1 checks lowest-index priority.
module tb_bridge_demux;
  import pocket_pkg::*;

  localparam int NS  = 4;
  localparam int LAT = 2;
  localparam logic [NS*32-1:0] BASE_MAIN = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] BASE_OVL  = {32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [NS-1:0]    LITTLE    = 4'b0001;

  typedef struct {
    int          cyc;
    logic [3:0]  swr;
    logic [3:0]  srd;
    logic        unm;
    logic        proto;
    logic [3:0]  ovl;
    logic        acc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] laneData;
    int          lane;
  } reqExp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rdExp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [31:0]      m_addr = '0;
  logic [31:0]      m_wr_data = '0;
  logic             m_wr = 1'b0;
  logic             m_rd = 1'b0;
  logic             m_endian_little = 1'b0;
  logic [31:0]      m_rd_data;
  logic [31:0]      s_addr;
  logic [NS*32-1:0] s_wr_data;
  logic [NS-1:0]    s_wr;
  logic [NS-1:0]    s_rd;
  logic [NS*32-1:0] s_rd_data;
  logic             unmapped_err;
  logic             proto_err;

  logic [31:0]      ovl_m_rd_data;
  logic [31:0]      ovl_s_addr;
  logic [NS*32-1:0] ovl_s_wr_data;
  logic [NS-1:0]    ovl_s_wr;
  logic [NS-1:0]    ovl_s_rd;
  logic [NS*32-1:0] ovl_s_rd_data = '0;
  logic             ovl_unmapped_err;
  logic             ovl_proto_err;

  int          cycle = 0;
  int          assertions = 0;
  int          failures = 0;
  bit          monitorOn = 1'b0;
  logic [31:0] expRd = '0;
  logic [31:0] slaveVal [NS];
  logic [LAT-1:0] hist [NS];
  reqExp_t     reqQ[$];
  rdExp_t      rdQ[$];

  bridge_demux #(
    .NUM_SLAVES    (NS),
    .SLAVE_BASE    (BASE_MAIN),
    .SLAVE_MASK    ({NS{32'hF000_0000}}),
    .RD_LATENCY    (LAT),
    .UNMAPPED_DATA (32'hFFFF_FFFF),
    .SLAVE_LITTLE  (LITTLE)
  ) dut (
    .clk (clk), .reset_n (reset_n), .m_addr (m_addr), .m_wr_data (m_wr_data),
    .m_wr (m_wr), .m_rd (m_rd), .m_endian_little (m_endian_little),
    .m_rd_data (m_rd_data), .s_addr (s_addr), .s_wr_data (s_wr_data),
    .s_wr (s_wr), .s_rd (s_rd), .s_rd_data (s_rd_data),
    .unmapped_err (unmapped_err), .proto_err (proto_err)
  );

  bridge_demux #(
    .NUM_SLAVES    (NS),
    .SLAVE_BASE    (BASE_OVL),
    .SLAVE_MASK    ({NS{32'hF000_0000}}),
    .RD_LATENCY    (LAT),
    .UNMAPPED_DATA (32'hFFFF_FFFF),
    .SLAVE_LITTLE  (LITTLE)
  ) dut_ovl (
    .clk (clk), .reset_n (reset_n), .m_addr (m_addr), .m_wr_data (m_wr_data),
    .m_wr (m_wr), .m_rd (m_rd), .m_endian_little (m_endian_little),
    .m_rd_data (ovl_m_rd_data), .s_addr (ovl_s_addr), .s_wr_data (ovl_s_wr_data),
    .s_wr (ovl_s_wr), .s_rd (ovl_s_rd), .s_rd_data (ovl_s_rd_data),
    .unmapped_err (ovl_unmapped_err), .proto_err (ovl_proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Slave model: data is valid exactly LAT cycles after its s_rd strobe,
  // otherwise the lane carries a recognisable junk pattern.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) hist[i] <= '0;
    end else begin
      for (int i = 0; i < NS; i++) hist[i] <= {hist[i][LAT-2:0], s_rd[i]};
    end
  end

  always_comb begin
    s_rd_data = '0;
    for (int i = 0; i < NS; i++) begin
      s_rd_data[32*i +: 32] = hist[i][LAT-1] ? slaveVal[i] : (32'h0BAD_0000 | 32'(i));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  // Drive one master cycle and queue what the DUT must show in response.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] eSwr,
                               input logic [3:0] eSrd, input logic eUnm, input logic eProto,
                               input logic [3:0] eOvl, input int lane,
                               input logic [31:0] eLane, input logic eRdPush,
                               input logic [31:0] eRdData);
    reqExp_t r;
    rdExp_t  d;
    m_wr      = wr;
    m_rd      = rd;
    m_addr    = addr;
    m_wr_data = data;
    r.cyc = cycle + 1; r.swr = eSwr; r.srd = eSrd; r.unm = eUnm; r.proto = eProto;
    r.ovl = eOvl; r.acc = wr | rd; r.wr = wr; r.addr = addr; r.laneData = eLane; r.lane = lane;
    reqQ.push_back(r);
    if (eRdPush) begin
      d.cyc = cycle + 2 + LAT;
      d.data = eRdData;
      rdQ.push_back(d);
    end
    @(posedge clk);
    #1;
    m_wr = 1'b0;
    m_rd = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every cycle compare strobes, errors and read data against the
  // queued expectations (no entry for this cycle means everything idle).
  always @(negedge clk) begin
    reqExp_t e;
    if (monitorOn) begin
      e = '{cyc: 0, swr: 4'b0, srd: 4'b0, unm: 1'b0, proto: 1'b0, ovl: 4'b0,
            acc: 1'b0, wr: 1'b0, addr: 32'h0, laneData: 32'h0, lane: 0};
      if (reqQ.size() > 0 && reqQ[0].cyc == cycle) e = reqQ.pop_front();
      checkOutput("s_wr", 32'(s_wr), 32'(e.swr));
      checkOutput("s_rd", 32'(s_rd), 32'(e.srd));
      checkOutput("unmapped_err", 32'(unmapped_err), 32'(e.unm));
      checkOutput("proto_err", 32'(proto_err), 32'(e.proto));
      checkOutput("ovl_s_wr", 32'(ovl_s_wr), 32'(e.ovl));
      if (e.acc) checkOutput("s_addr", s_addr, e.addr);
      if (e.wr) checkOutput("s_wr_data lane", s_wr_data[32*e.lane +: 32], e.laneData);
      if (rdQ.size() > 0 && rdQ[0].cyc == cycle) expRd = rdQ.pop_front().data;
      checkOutput("m_rd_data", m_rd_data, expRd);
    end
  end

  initial begin
    logic [31:0] lane0Wr;
    logic [31:0] lane0Ovl;
    logic [31:0] endianRd;
`ifdef BRIDGE_DEMUX_ENDIAN_SWAP_EN
    lane0Wr  = 32'h7856_3412;
    lane0Ovl = 32'h0100_FECA;
    endianRd = 32'hDDCC_BBAA;
`else
    lane0Wr  = 32'h1234_5678;
    lane0Ovl = 32'hCAFE_0001;
    endianRd = 32'hAABB_CCDD;
`endif
    slaveVal[0] = 32'h1111_1111;
    slaveVal[1] = 32'h2222_2222;
    slaveVal[2] = 32'h3333_3333;
    slaveVal[3] = 32'h4444_4444;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset s_wr", 32'(s_wr), 32'h0);
    checkOutput("reset s_rd", 32'(s_rd), 32'h0);
    checkOutput("reset s_addr", s_addr, 32'h0);
    checkOutput("reset m_rd_data", m_rd_data, 32'h0);
    checkOutput("reset errs", {30'h0, unmapped_err, proto_err}, 32'h0);
    reset_n = 1'b1;
    monitorOn = 1'b1;
    idleCycles(2);

    // Write to slave 2.
    applyStimulus(1, 0, 32'h2000_0010, 32'hDEAD_BEEF, 4'b0100, 4'b0000, 0, 0, 4'b0100, 2, 32'hDEAD_BEEF, 0, 0);
    idleCycles(2);
    // Back-to-back reads to slaves 0, 1, 3.
    applyStimulus(0, 1, 32'h0000_0004, 0, 4'b0000, 4'b0001, 0, 0, 4'b0000, 0, 0, 1, 32'h1111_1111);
    applyStimulus(0, 1, 32'h1000_0008, 0, 4'b0000, 4'b0010, 0, 0, 4'b0000, 0, 0, 1, 32'h2222_2222);
    applyStimulus(0, 1, 32'h3000_000C, 0, 4'b0000, 4'b1000, 0, 0, 4'b0000, 0, 0, 1, 32'h4444_4444);
    idleCycles(LAT + 3);
    // Unmapped read and unmapped write.
    applyStimulus(0, 1, 32'h5000_0000, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 32'hFFFF_FFFF);
    idleCycles(LAT + 3);
    applyStimulus(1, 0, 32'h7000_0000, 32'h0000_0077, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 32'h0000_0077, 0, 0);
    idleCycles(1);
    // Read, write in the middle, read: write must not disturb completions.
    applyStimulus(0, 1, 32'h1000_0000, 0, 4'b0000, 4'b0010, 0, 0, 4'b0000, 0, 0, 1, 32'h2222_2222);
    applyStimulus(1, 0, 32'h2000_0020, 32'h0BEE_F00D, 4'b0100, 4'b0000, 0, 0, 4'b0100, 2, 32'h0BEE_F00D, 0, 0);
    applyStimulus(0, 1, 32'h3000_0000, 0, 4'b0000, 4'b1000, 0, 0, 4'b0000, 0, 0, 1, 32'h4444_4444);
    idleCycles(LAT + 3);
    // Overlapping windows: only slave 0 of the overlap instance sees the write.
    applyStimulus(1, 0, 32'h0000_0000, 32'hCAFE_0001, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0, lane0Ovl, 0, 0);
    idleCycles(1);
    // Simultaneous write and read: write forwarded, read dropped.
    applyStimulus(1, 1, 32'h3000_0000, 32'h5555_AAAA, 4'b1000, 4'b0000, 0, 1, 4'b1000, 3, 32'h5555_AAAA, 0, 0);
    idleCycles(LAT + 3);

    // Reset one cycle after a read: outputs clear at once, read never completes.
    monitorOn = 1'b0;
    m_addr = 32'h1000_0000;
    m_rd = 1'b1;
    @(posedge clk);
    #1;
    m_rd = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset s_rd", 32'(s_rd), 32'h0);
    checkOutput("async reset s_wr", 32'(s_wr), 32'h0);
    checkOutput("async reset s_addr", s_addr, 32'h0);
    checkOutput("async reset s_wr_data", s_wr_data[31:0] | s_wr_data[127:96], 32'h0);
    checkOutput("async reset m_rd_data", m_rd_data, 32'h0);
    checkOutput("async reset errs", {30'h0, unmapped_err, proto_err}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    reqQ.delete();
    rdQ.delete();
    expRd = '0;
    #1;
    monitorOn = 1'b1;
    idleCycles(LAT + 6);

    // Endianness: slave 0 is little-endian, master is big-endian.
    applyStimulus(1, 0, 32'h0000_0100, 32'h1234_5678, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0, lane0Wr, 0, 0);
    slaveVal[0] = 32'hAABB_CCDD;
    applyStimulus(0, 1, 32'h0000_0100, 0, 4'b0000, 4'b0001, 0, 0, 4'b0000, 0, 0, 1, endianRd);
    idleCycles(LAT + 4);

    monitorOn = 1'b0;
    checkOutput("request queue drained", 32'(reqQ.size()), 32'h0);
    checkOutput("read queue drained", 32'(rdQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
